pack_scheduler: RTL and testbench

Controller for the ping-pong packet memory (two 1976-bit banks plus a constant blank pack).
- Write side: accepts a byte stream, generates the write address and per-bank write enables, and tracks which banks are full.
- Read side: on each output-bit tick, generates the read address and selects the output source (bank 0, bank 1 or blank) frame by frame.
- Sits between the byte-stream framer and the bit-serial modulator front end.

---
 rtl/pack_pkg.sv | 19 +
 rtl/pack_rd_sequencer.sv | 80 ++++++++
 rtl/pack_scheduler.sv | 93 +++++++++
 tb/tb_pack_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack_pkg.sv
// Shared constants for the ping-pong pack memory controller: source encodings
// and default pack geometry.
package pack_pkg;

    localparam logic [1:0] SRC_BLANK = 2'b00;
    localparam logic [1:0] SRC_BANK0 = 2'b01;
    localparam logic [1:0] SRC_BANK1 = 2'b10;

    localparam int SIZE_BIT_PACK_DEF      = 1976;
    localparam int SIZE_INPUT_BIT_DEF     = 8;
    localparam int LENGTHE_INPUT_BIT_DEF  = SIZE_BIT_PACK_DEF / SIZE_INPUT_BIT_DEF;
    localparam int LENGTHE_OUTPUT_BIT_DEF = SIZE_BIT_PACK_DEF;
    localparam int SIZE_CNT_DEF           = 16;

    function automatic logic [1:0] bank_src(input logic bank);
        return bank ? SRC_BANK1 : SRC_BANK0;
    endfunction

endpackage

// File: rtl/pack_rd_sequencer.sv
// Read-side sequencer: walks the read address on each bit tick and picks the
// frame source (bank or blank) at every frame boundary.
module pack_rd_sequencer
    import pack_pkg::*;
#(
    parameter int LEN_OUT = LENGTHE_OUTPUT_BIT_DEF,
    parameter int ADDR_W  = $clog2(LEN_OUT),
    parameter int CNT_W   = SIZE_CNT_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_bit_en,
    input  logic [1:0]        i_fill,
    input  logic [1:0]        i_fill_set,
    output logic [1:0]        o_release,
    output logic [ADDR_W-1:0] o_addr_out,
    output logic [1:0]        o_src,
    output logic [1:0]        o_src_d,
    output logic              o_frame_start,
    output logic [CNT_W-1:0]  o_blank_cnt
);

    localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(LEN_OUT - 1);

    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        src_q, src_d;
    logic [1:0]        src_dly_q;
    logic [CNT_W-1:0]  blank_cnt_q, blank_cnt_d;
    logic              frame_end;
    logic [1:0]        release_mask;
    logic [1:0]        fill_after;

    always_comb begin
        frame_end    = i_bit_en && (rd_cnt_q == LAST_RD);
        rd_cnt_d     = rd_cnt_q;
        rd_bank_d    = rd_bank_q;
        src_d        = src_q;
        blank_cnt_d  = blank_cnt_q;
        release_mask = 2'b00;
        fill_after   = 2'b00;
        if (i_bit_en)
            rd_cnt_d = frame_end ? '0 : rd_cnt_q + 1'b1;
        if (frame_end) begin
            if (src_q != SRC_BLANK) begin
                release_mask = (src_q == SRC_BANK1) ? 2'b10 : 2'b01;
                rd_bank_d    = ~rd_bank_q;
            end else if (blank_cnt_q != '1) begin
                blank_cnt_d = blank_cnt_q + 1'b1;
            end
            // Include a pack finishing on this very clock so it plays without a blank gap.
            fill_after = (i_fill | i_fill_set) & ~release_mask;
            src_d      = fill_after[rd_bank_d] ? bank_src(rd_bank_d) : SRC_BLANK;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            src_q       <= SRC_BLANK;
            src_dly_q   <= SRC_BLANK;
            blank_cnt_q <= '0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            src_q       <= src_d;
            src_dly_q   <= src_q;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign o_release     = release_mask;
    assign o_addr_out    = rd_cnt_q;
    assign o_src         = src_q;
    assign o_src_d       = src_dly_q;
    assign o_frame_start = i_bit_en && (rd_cnt_q == '0);
    assign o_blank_cnt   = blank_cnt_q;

endmodule

// File: rtl/pack_scheduler.sv
// Ping-pong pack memory controller: write counter and bank-full flags here,
// frame playout delegated to pack_rd_sequencer.
module pack_scheduler
    import pack_pkg::*;
#(
    parameter int SIZE_BIT_PACK      = SIZE_BIT_PACK_DEF,
    parameter int SIZE_INPUT_BIT     = SIZE_INPUT_BIT_DEF,
    parameter int LENGTHE_INPUT_BIT  = SIZE_BIT_PACK / SIZE_INPUT_BIT,
    parameter int LENGTHE_OUTPUT_BIT = SIZE_BIT_PACK,
    parameter int SIZE_ADDR_INPUT    = $clog2(LENGTHE_INPUT_BIT),
    parameter int SIZE_ADDR_OUTPUT   = $clog2(LENGTHE_OUTPUT_BIT),
    parameter int SIZE_CNT           = SIZE_CNT_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [SIZE_ADDR_INPUT-1:0]  o_addr_in,
    output logic [1:0]                  o_we,
    input  logic                        i_bit_en,
    output logic [SIZE_ADDR_OUTPUT-1:0] o_addr_out,
    output logic [1:0]                  o_src,
    output logic [1:0]                  o_src_d,
    output logic                        o_frame_start,
    output logic [1:0]                  o_fill,
    output logic [SIZE_CNT-1:0]         o_blank_cnt
);

    localparam logic [SIZE_ADDR_INPUT-1:0] LAST_WR = SIZE_ADDR_INPUT'(LENGTHE_INPUT_BIT - 1);

    logic [SIZE_ADDR_INPUT-1:0] wr_cnt_q, wr_cnt_d;
    logic                       wr_bank_q, wr_bank_d;
    logic [1:0]                 fill_q, fill_d;
    logic                       ready_q, ready_d;
    logic                       accept;
    logic                       wr_done;
    logic [1:0]                 fill_set;
    logic [1:0]                 release_mask;

    always_comb begin
        accept   = i_valid & ready_q;
        wr_done  = accept && (wr_cnt_q == LAST_WR);
        fill_set = wr_done ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
        wr_cnt_d = wr_cnt_q;
        if (accept)
            wr_cnt_d = wr_done ? '0 : wr_cnt_q + 1'b1;
        wr_bank_d = wr_bank_q ^ wr_done;
        // Set and release never target the same bank, so ordering here is immaterial.
        fill_d  = (fill_q | fill_set) & ~release_mask;
        ready_d = ~fill_d[wr_bank_d];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            fill_q    <= 2'b00;
            ready_q   <= 1'b1;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            fill_q    <= fill_d;
            ready_q   <= ready_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_we
        assign o_we[gi] = accept & (wr_bank_q == 1'(gi));
    end

    assign o_ready   = ready_q;
    assign o_addr_in = wr_cnt_q;
    assign o_fill    = fill_q;

    pack_rd_sequencer #(
        .LEN_OUT (LENGTHE_OUTPUT_BIT),
        .ADDR_W  (SIZE_ADDR_OUTPUT),
        .CNT_W   (SIZE_CNT)
    ) u_rd_seq (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_bit_en      (i_bit_en),
        .i_fill        (fill_q),
        .i_fill_set    (fill_set),
        .o_release     (release_mask),
        .o_addr_out    (o_addr_out),
        .o_src         (o_src),
        .o_src_d       (o_src_d),
        .o_frame_start (o_frame_start),
        .o_blank_cnt   (o_blank_cnt)
    );

endmodule

// File: tb/tb_pack_scheduler.sv
// Self-checking bench for pack_scheduler: write words and frame sources are
// predicted into scoreboards and compared as the DUT presents them.
module tb_pack_scheduler;
    import pack_pkg::*;

    localparam int LI = 247;
    localparam int LO = 1976;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_bit_en = 1'b0;
    logic        o_ready;
    logic [7:0]  o_addr_in;
    logic [1:0]  o_we;
    logic [10:0] o_addr_out;
    logic [1:0]  o_src;
    logic [1:0]  o_src_d;
    logic        o_frame_start;
    logic [1:0]  o_fill;
    logic [15:0] o_blank_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_wr_q[$];
    logic [1:0] exp_src_q[$];

    pack_scheduler dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_addr_in     (o_addr_in),
        .o_we          (o_we),
        .i_bit_en      (i_bit_en),
        .o_addr_out    (o_addr_out),
        .o_src         (o_src),
        .o_src_d       (o_src_d),
        .o_frame_start (o_frame_start),
        .o_fill        (o_fill),
        .o_blank_cnt   (o_blank_cnt)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Drive one clock's inputs just after the rising edge, return at the falling edge.
    task automatic tick(input logic v, input logic be);
        @(posedge i_clk);
        #1;
        i_valid  = v;
        i_bit_en = be;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_valid   = 1'b0;
        i_bit_en  = 1'b0;
        i_reset_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #2;
        i_reset_n = 1'b1;
        exp_wr_q.delete();
        exp_src_q.delete();
    endtask

    task automatic test_reset();
        i_valid   = 1'b0;
        i_bit_en  = 1'b0;
        i_reset_n = 1'b0;
        repeat (2) @(negedge i_clk);
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", o_ready); end
        n_tests++; if (o_addr_in !== 8'd0) begin n_fail++; $display("FAIL reset_addr_in: got %0d exp 0", o_addr_in); end
        n_tests++; if (o_we !== 2'b00) begin n_fail++; $display("FAIL reset_we: got %b exp 00", o_we); end
        n_tests++; if (o_addr_out !== 11'd0) begin n_fail++; $display("FAIL reset_addr_out: got %0d exp 0", o_addr_out); end
        n_tests++; if (o_src !== 2'b00) begin n_fail++; $display("FAIL reset_src: got %b exp 00", o_src); end
        n_tests++; if (o_src_d !== 2'b00) begin n_fail++; $display("FAIL reset_src_d: got %b exp 00", o_src_d); end
        n_tests++; if (o_frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b exp 0", o_frame_start); end
        n_tests++; if (o_fill !== 2'b00) begin n_fail++; $display("FAIL reset_fill: got %b exp 00", o_fill); end
        n_tests++; if (o_blank_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_blank_cnt: got %0d exp 0", o_blank_cnt); end
        do_reset();
    endtask

    task automatic test_idle();
        int fs_bad = 0;
        int addr_bad = 0;
        logic [1:0] exp_s;
        do_reset();
        repeat (3) exp_src_q.push_back(SRC_BLANK);
        for (int t = 0; t < 3 * LO; t++) begin
            repeat (3) begin
                tick(1'b0, 1'b0);
                if (o_frame_start !== 1'b0) fs_bad++;
            end
            tick(1'b0, 1'b1);
            if (o_frame_start !== ((t % LO) == 0)) fs_bad++;
            if (o_addr_out !== 11'(t % LO)) addr_bad++;
            if (o_frame_start === 1'b1) begin
                n_tests++;
                if (exp_src_q.size() == 0) begin
                    n_fail++; $display("FAIL idle_frame: got extra frame start at tick %0d, exp none", t);
                end else begin
                    exp_s = exp_src_q.pop_front();
                    if (o_src !== exp_s) begin n_fail++; $display("FAIL idle_src: got %b exp %b at tick %0d", o_src, exp_s, t); end
                end
            end
        end
        tick(1'b0, 1'b0);
        n_tests++; if (fs_bad != 0) begin n_fail++; $display("FAIL idle_frame_start: got %0d misplaced pulses exp 0", fs_bad); end
        n_tests++; if (addr_bad != 0) begin n_fail++; $display("FAIL idle_addr_out: got %0d bad addresses exp 0", addr_bad); end
        n_tests++; if (o_blank_cnt !== 16'd3) begin n_fail++; $display("FAIL idle_blank_cnt: got %0d exp 3", o_blank_cnt); end
        n_tests++; if (o_src !== SRC_BLANK) begin n_fail++; $display("FAIL idle_src_end: got %b exp 00", o_src); end
        n_tests++; if (exp_src_q.size() != 0) begin n_fail++; $display("FAIL idle_frames_seen: got %0d frames missing exp 0", exp_src_q.size()); end
    endtask

    task automatic test_single_pack();
        logic [9:0] exp_w;
        logic [1:0] exp_s;
        do_reset();
        exp_src_q.push_back(SRC_BLANK);
        exp_src_q.push_back(SRC_BANK0);
        exp_src_q.push_back(SRC_BLANK);
        for (int c = 0; c <= 2 * LO; c++) begin
            if (c < LI) exp_wr_q.push_back({2'b01, 8'(c)});
            tick(c < LI, 1'b1);
            if (c < LI) begin
                exp_w = exp_wr_q.pop_front();
                n_tests++;
                if ({o_we, o_addr_in} !== exp_w) begin
                    n_fail++; $display("FAIL single_wr: got we=%b addr=%0d exp we=%b addr=%0d", o_we, o_addr_in, exp_w[9:8], exp_w[7:0]);
                end
            end
            if (o_frame_start === 1'b1) begin
                n_tests++;
                if (exp_src_q.size() == 0) begin
                    n_fail++; $display("FAIL single_frame: got extra frame start at clock %0d, exp none", c);
                end else begin
                    exp_s = exp_src_q.pop_front();
                    if (o_src !== exp_s) begin n_fail++; $display("FAIL single_src: got %b exp %b at clock %0d", o_src, exp_s, c); end
                end
            end
            if (c == LI) begin
                n_tests++; if (o_fill !== 2'b01) begin n_fail++; $display("FAIL single_fill_set: got %b exp 01", o_fill); end
            end
            if (c == LO) begin
                n_tests++; if (o_src_d !== 2'b00) begin n_fail++; $display("FAIL single_src_d_lag: got %b exp 00", o_src_d); end
            end
            if (c == LO + 1) begin
                n_tests++; if (o_src_d !== 2'b01) begin n_fail++; $display("FAIL single_src_d: got %b exp 01", o_src_d); end
            end
        end
        n_tests++; if (o_fill !== 2'b00) begin n_fail++; $display("FAIL single_fill_clear: got %b exp 00", o_fill); end
        n_tests++; if (o_blank_cnt !== 16'd1) begin n_fail++; $display("FAIL single_blank_cnt: got %0d exp 1", o_blank_cnt); end
        n_tests++; if (exp_src_q.size() != 0) begin n_fail++; $display("FAIL single_frames_seen: got %0d frames missing exp 0", exp_src_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [9:0] exp_w;
        logic [1:0] exp_s;
        do_reset();
        for (int i = 0; i < 2 * LI; i++) begin
            exp_wr_q.push_back({(i < LI) ? 2'b01 : 2'b10, 8'(i % LI)});
            tick(1'b1, 1'b0);
            exp_w = exp_wr_q.pop_front();
            n_tests++;
            if ({o_we, o_addr_in} !== exp_w) begin
                n_fail++; $display("FAIL bp_wr: got we=%b addr=%0d exp we=%b addr=%0d", o_we, o_addr_in, exp_w[9:8], exp_w[7:0]);
            end
        end
        tick(1'b1, 1'b0);
        n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b exp 0", o_ready); end
        n_tests++; if (o_we !== 2'b00) begin n_fail++; $display("FAIL bp_we_blocked: got %b exp 00", o_we); end
        n_tests++; if (o_fill !== 2'b11) begin n_fail++; $display("FAIL bp_fill_full: got %b exp 11", o_fill); end
        n_tests++; if (o_addr_in !== 8'd0) begin n_fail++; $display("FAIL bp_addr_hold: got %0d exp 0", o_addr_in); end
        exp_src_q.push_back(SRC_BLANK);
        exp_src_q.push_back(SRC_BANK0);
        for (int c = 0; c < 2 * LO; c++) begin
            tick(1'b0, 1'b1);
            if (o_frame_start === 1'b1) begin
                n_tests++;
                if (exp_src_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_frame: got extra frame start at tick %0d, exp none", c);
                end else begin
                    exp_s = exp_src_q.pop_front();
                    if (o_src !== exp_s) begin n_fail++; $display("FAIL bp_src: got %b exp %b at tick %0d", o_src, exp_s, c); end
                end
            end
            if (c == 2 * LO - 1) begin
                n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_before_release: got %b exp 0", o_ready); end
            end
        end
        exp_wr_q.push_back({2'b01, 8'd0});
        tick(1'b1, 1'b0);
        exp_w = exp_wr_q.pop_front();
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_release: got %b exp 1", o_ready); end
        n_tests++;
        if ({o_we, o_addr_in} !== exp_w) begin
            n_fail++; $display("FAIL bp_wr_resume: got we=%b addr=%0d exp we=%b addr=%0d", o_we, o_addr_in, exp_w[9:8], exp_w[7:0]);
        end
        n_tests++; if (o_fill !== 2'b10) begin n_fail++; $display("FAIL bp_fill_after_release: got %b exp 10", o_fill); end
        n_tests++; if (o_src !== SRC_BANK1) begin n_fail++; $display("FAIL bp_src_next: got %b exp 10", o_src); end
        n_tests++; if (exp_src_q.size() != 0) begin n_fail++; $display("FAIL bp_frames_seen: got %0d frames missing exp 0", exp_src_q.size()); end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        logic [9:0] exp_w;
        logic [1:0] exp_s;
        logic       v;
        int         b1_start = 2 * LO - LI;
        do_reset();
        exp_src_q.push_back(SRC_BLANK);
        exp_src_q.push_back(SRC_BANK0);
        exp_src_q.push_back(SRC_BANK1);
        for (int c = 0; c <= 2 * LO; c++) begin
            v = (c < LI) || (c >= b1_start && c < 2 * LO);
            if (c < LI) exp_wr_q.push_back({2'b01, 8'(c)});
            else if (v) exp_wr_q.push_back({2'b10, 8'(c - b1_start)});
            tick(v, 1'b1);
            if (v) begin
                exp_w = exp_wr_q.pop_front();
                n_tests++;
                if ({o_we, o_addr_in} !== exp_w) begin
                    n_fail++; $display("FAIL bypass_wr: got we=%b addr=%0d exp we=%b addr=%0d at clock %0d", o_we, o_addr_in, exp_w[9:8], exp_w[7:0], c);
                end
            end
            if (o_frame_start === 1'b1) begin
                n_tests++;
                if (exp_src_q.size() == 0) begin
                    n_fail++; $display("FAIL bypass_frame: got extra frame start at clock %0d, exp none", c);
                end else begin
                    exp_s = exp_src_q.pop_front();
                    if (o_src !== exp_s) begin n_fail++; $display("FAIL bypass_src: got %b exp %b at clock %0d", o_src, exp_s, c); end
                end
            end
        end
        n_tests++; if (o_fill !== 2'b10) begin n_fail++; $display("FAIL bypass_fill: got %b exp 10", o_fill); end
        n_tests++; if (exp_src_q.size() != 0) begin n_fail++; $display("FAIL bypass_frames_seen: got %0d frames missing exp 0", exp_src_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c <= LO + 1000; c++) tick(c < 2 * LI, 1'b1);
        n_tests++; if (o_addr_out !== 11'd1000) begin n_fail++; $display("FAIL mid_addr_out: got %0d exp 1000", o_addr_out); end
        n_tests++; if (o_src !== SRC_BANK0) begin n_fail++; $display("FAIL mid_src: got %b exp 01", o_src); end
        n_tests++; if (o_fill !== 2'b11) begin n_fail++; $display("FAIL mid_fill: got %b exp 11", o_fill); end
        #1;
        i_valid   = 1'b0;
        i_bit_en  = 1'b0;
        i_reset_n = 1'b0;
        #1;
        n_tests++; if (o_fill !== 2'b00) begin n_fail++; $display("FAIL mid_rst_fill: got %b exp 00", o_fill); end
        n_tests++; if (o_addr_out !== 11'd0) begin n_fail++; $display("FAIL mid_rst_addr_out: got %0d exp 0", o_addr_out); end
        n_tests++; if (o_src !== SRC_BLANK) begin n_fail++; $display("FAIL mid_rst_src: got %b exp 00", o_src); end
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b exp 1", o_ready); end
        n_tests++; if (o_blank_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_blank_cnt: got %0d exp 0", o_blank_cnt); end
        @(posedge i_clk);
        #2;
        i_reset_n = 1'b1;
        tick(1'b0, 1'b1);
        n_tests++; if (o_frame_start !== 1'b1) begin n_fail++; $display("FAIL mid_post_frame_start: got %b exp 1", o_frame_start); end
        n_tests++; if (o_src !== SRC_BLANK) begin n_fail++; $display("FAIL mid_post_src: got %b exp 00", o_src); end
        tick(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_pack();
        test_backpressure();
        test_bypass();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
